// File: rtl/la_capture_trigger.sv
// rtl/la_capture_trigger.sv - logic analyser sample capture, trigger and circular window buffer
module la_capture_trigger #(
    parameter int DEPTH_LOG2 = 10,
    parameter int PRE_TRIG   = 256
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [7:0]            data_in,
    input  logic                  trigger_en,
    input  logic [2:0]            cpu_chn_sel,
    input  logic [2:0]            cpu_mode_sel,
    input  logic [3:0]            cpu_freq_sel,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [DEPTH_LOG2-1:0] trig_addr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Terminal counts for the pre-trigger and post-trigger phases.
    localparam logic [DEPTH_LOG2-1:0] PRE_LAST  = DEPTH_LOG2'(PRE_TRIG - 1);
    localparam logic [DEPTH_LOG2-1:0] PRE_OFF   = DEPTH_LOG2'(PRE_TRIG);
    localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(DEPTH - PRE_TRIG - 2);
    // With PRE_TRIG = DEPTH-1 the trigger sample is the last one of the window.
    localparam bit                    POST_EMPTY = (PRE_TRIG == DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [7:0]              sync1_q;
    logic [7:0]              ds_q;
    logic [7:0]              prev_q;
    logic [2:0]              chn_q;
    logic [2:0]              mode_q;
    logic [3:0]              freq_q;
    logic [10:0]             div_q;
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   cnt_q;
    logic [DEPTH_LOG2-1:0]   start_q;
    logic                    busy_q;
    logic                    done_q;
    logic [7:0]              rd_data_q;
    logic [7:0]              mem [DEPTH];

    logic [10:0]             period_mask_d;
    logic                    tick_d;
    logic                    wr_en_d;
    logic                    hit_d;
    logic                    cur_bit_d;
    logic                    prev_bit_d;
    logic [3:0]              freq_clamp_d;
    logic [DEPTH_LOG2-1:0]   rd_phys_d;

    // Two-flop synchroniser for the asynchronous probe bus.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= '0;
            ds_q    <= '0;
        end else begin
            sync1_q <= data_in;
            ds_q    <= sync1_q;
        end
    end

    // Sample tick, trigger condition and read address decode.
    always_comb begin
        period_mask_d = (11'd1 << freq_q) - 11'd1;
        tick_d        = (div_q == period_mask_d);
        wr_en_d       = tick_d && busy_q;
        freq_clamp_d  = (cpu_freq_sel > 4'd11) ? 4'd11 : cpu_freq_sel;
        cur_bit_d     = ds_q[chn_q];
        prev_bit_d    = prev_q[chn_q];
        rd_phys_d     = start_q + rd_addr;
        case (mode_q)
            3'd0:    hit_d = !prev_bit_d && cur_bit_d;
            3'd1:    hit_d = prev_bit_d && !cur_bit_d;
            3'd2:    hit_d = prev_bit_d != cur_bit_d;
            3'd3:    hit_d = cur_bit_d;
            3'd4:    hit_d = !cur_bit_d;
            default: hit_d = 1'b1;
        endcase
    end

    // Capture FSM: arming, divider, write pointer, phase counters and status flags.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            prev_q   <= '0;
            chn_q    <= '0;
            mode_q   <= '0;
            freq_q   <= '0;
            div_q    <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            start_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (trigger_en) begin
                        chn_q    <= cpu_chn_sel;
                        mode_q   <= cpu_mode_sel;
                        freq_q   <= freq_clamp_d;
                        div_q    <= '0;
                        wr_ptr_q <= '0;
                        cnt_q    <= '0;
                        done_q   <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_PRE;
                    end
                end
                default: begin
                    div_q <= tick_d ? 11'd0 : div_q + 11'd1;
                    if (tick_d) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                        prev_q   <= ds_q;
                        case (state_q)
                            S_PRE: begin
                                if (cnt_q == PRE_LAST) begin
                                    cnt_q   <= '0;
                                    state_q <= S_WAIT;
                                end else begin
                                    cnt_q <= cnt_q + 1'b1;
                                end
                            end
                            S_WAIT: begin
                                if (hit_d) begin
                                    start_q <= wr_ptr_q - PRE_OFF;
                                    cnt_q   <= '0;
                                    if (POST_EMPTY) begin
                                        busy_q  <= 1'b0;
                                        done_q  <= 1'b1;
                                        state_q <= S_DONE;
                                    end else begin
                                        state_q <= S_POST;
                                    end
                                end
                            end
                            S_POST: begin
                                if (cnt_q == POST_LAST) begin
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                    state_q <= S_DONE;
                                end else begin
                                    cnt_q <= cnt_q + 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    // Sample buffer write port; only active on ticks while capturing.
    always_ff @(posedge sys_clk) begin
        if (wr_en_d) begin
            mem[wr_ptr_q] <= ds_q;
        end
    end

    // Registered read port, addressed relative to the window start.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_phys_d];
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign trig_addr = start_q;

endmodule

// File: tb/tb_la_capture_trigger.sv
// tb/tb_la_capture_trigger.sv - directed self-checking bench for la_capture_trigger
module tb_la_capture_trigger;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic [7:0] data_in;
    logic       trigger_en;
    logic [2:0] cpu_chn_sel;
    logic [2:0] cpu_mode_sel;
    logic [3:0] cpu_freq_sel;
    logic [9:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [9:0] trig_addr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int arm_cyc = 0;

    la_capture_trigger #(.DEPTH_LOG2(10), .PRE_TRIG(256)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .data_in      (data_in),
        .trigger_en   (trigger_en),
        .cpu_chn_sel  (cpu_chn_sel),
        .cpu_mode_sel (cpu_mode_sel),
        .cpu_freq_sel (cpu_freq_sel),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .trig_addr    (trig_addr)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Arm pulse on edge E0; afterwards we sit on the negedge following E0.
    task automatic do_arm(input logic [2:0] chn, input logic [2:0] mode, input logic [3:0] f);
        @(negedge sys_clk);
        cpu_chn_sel  = chn;
        cpu_mode_sel = mode;
        cpu_freq_sel = f;
        trigger_en   = 1'b1;
        @(negedge sys_clk);
        trigger_en = 1'b0;
        arm_cyc    = cyc;
    endtask

    // Advance to the negedge after edge E(n) counted from the arm edge.
    task automatic goto_edge(input int n);
        while (cyc - arm_cyc < n) @(negedge sys_clk);
    endtask

    task automatic wait_done(input int limit, output int edges, output bit busy_gap);
        busy_gap = 1'b0;
        while (!done && (cyc - arm_cyc < limit)) begin
            if (!busy) busy_gap = 1'b1;
            @(negedge sys_clk);
        end
        edges = cyc - arm_cyc;
    endtask

    task automatic read_buf(input logic [9:0] addr, output logic [7:0] v);
        rd_addr = addr;
        @(negedge sys_clk);
        v = rd_data;
    endtask

    task automatic test_reset;
        sys_rst_n    = 1'b0;
        data_in      = 8'h00;
        trigger_en   = 1'b0;
        cpu_chn_sel  = 3'd0;
        cpu_mode_sel = 3'd0;
        cpu_freq_sel = 4'd0;
        rd_addr      = 10'd0;
        repeat (3) @(negedge sys_clk);
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
        end
        n_tests++;
        if (rd_data !== 8'h00 || trig_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd_data=%0h trig_addr=%0d expected 0 0", rd_data, trig_addr);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
    endtask

    task automatic test_rising;
        int         e;
        bit         g;
        logic [7:0] v;
        data_in = 8'h00;
        repeat (3) @(negedge sys_clk);
        do_arm(3'd2, 3'd0, 4'd0);
        n_tests++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL rising_arm_flags: got busy=%b done=%b expected 1 0", busy, done);
        end
        goto_edge(398);
        data_in = 8'h04;
        wait_done(3000, e, g);
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || e != 1168) begin
            n_fail++;
            $display("FAIL rising_done: got done=%b busy=%b edge=%0d expected 1 0 1168", done, busy, e);
        end
        n_tests++;
        if (trig_addr !== 10'd144) begin
            n_fail++;
            $display("FAIL rising_trig_addr: got %0d expected 144", trig_addr);
        end
        read_buf(10'd255, v);
        n_tests++;
        if (v !== 8'h00) begin
            n_fail++;
            $display("FAIL rising_rd255: got %0h expected 00", v);
        end
        read_buf(10'd256, v);
        n_tests++;
        if (v !== 8'h04) begin
            n_fail++;
            $display("FAIL rising_rd256: got %0h expected 04", v);
        end
        read_buf(10'd1023, v);
        n_tests++;
        if (v !== 8'h04) begin
            n_fail++;
            $display("FAIL rising_rd1023: got %0h expected 04", v);
        end
    endtask

    task automatic test_pre_ignored;
        int         e;
        bit         g;
        logic [7:0] v;
        data_in = 8'h01;
        repeat (3) @(negedge sys_clk);
        do_arm(3'd0, 3'd1, 4'd0);
        goto_edge(8);
        data_in = 8'h00;
        goto_edge(18);
        data_in = 8'h01;
        goto_edge(598);
        data_in = 8'h00;
        wait_done(3000, e, g);
        n_tests++;
        if (done !== 1'b1 || e != 1368) begin
            n_fail++;
            $display("FAIL pre_done: got done=%b edge=%0d expected 1 1368", done, e);
        end
        n_tests++;
        if (trig_addr !== 10'd344) begin
            n_fail++;
            $display("FAIL pre_trig_addr: got %0d expected 344", trig_addr);
        end
        read_buf(10'd255, v);
        n_tests++;
        if (v !== 8'h01) begin
            n_fail++;
            $display("FAIL pre_rd255: got %0h expected 01", v);
        end
        read_buf(10'd256, v);
        n_tests++;
        if (v !== 8'h00) begin
            n_fail++;
            $display("FAIL pre_rd256: got %0h expected 00", v);
        end
    endtask

    task automatic test_force_div;
        int e;
        bit g;
        data_in = 8'h5A;
        repeat (3) @(negedge sys_clk);
        do_arm(3'd0, 3'd5, 4'd3);
        wait_done(9000, e, g);
        n_tests++;
        if (done !== 1'b1 || e < 8188 || e > 8196) begin
            n_fail++;
            $display("FAIL force_done_time: got done=%b edge=%0d expected 1 8192", done, e);
        end
        n_tests++;
        if (g !== 1'b0) begin
            n_fail++;
            $display("FAIL force_busy_held: got gap=%b expected 0", g);
        end
        n_tests++;
        if (trig_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL force_trig_addr: got %0d expected 0", trig_addr);
        end
    endtask

    task automatic test_wrap;
        int         e;
        bit         g;
        logic [7:0] v;
        data_in = 8'h00;
        repeat (3) @(negedge sys_clk);
        do_arm(3'd7, 3'd3, 4'd0);
        goto_edge(1498);
        data_in = 8'h80;
        wait_done(4000, e, g);
        n_tests++;
        if (done !== 1'b1 || e != 2268) begin
            n_fail++;
            $display("FAIL wrap_done: got done=%b edge=%0d expected 1 2268", done, e);
        end
        n_tests++;
        if (trig_addr !== 10'd220) begin
            n_fail++;
            $display("FAIL wrap_trig_addr: got %0d expected 220", trig_addr);
        end
        read_buf(10'd256, v);
        n_tests++;
        if (v[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_rd256_bit7: got %b expected 1", v[7]);
        end
        read_buf(10'd255, v);
        n_tests++;
        if (v[7] !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_rd255_bit7: got %b expected 0", v[7]);
        end
    endtask

    task automatic test_back_to_back;
        data_in = 8'h00;
        repeat (3) @(negedge sys_clk);
        do_arm(3'd0, 3'd5, 4'd0);
        goto_edge(600);
        trigger_en = 1'b1;
        @(negedge sys_clk);
        trigger_en = 1'b0;
        goto_edge(1023);
        n_tests++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_before_last: got busy=%b done=%b expected 1 0", busy, done);
        end
        trigger_en = 1'b1;
        @(negedge sys_clk);
        trigger_en = 1'b0;
        n_tests++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_done_edge: got busy=%b done=%b expected 0 1", busy, done);
        end
        @(negedge sys_clk);
        n_tests++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL b2b_arm_on_last_ignored: got busy=%b done=%b expected 0 1", busy, done);
        end
    endtask

    task automatic test_reset_mid_post;
        int         e;
        bit         g;
        logic [7:0] v;
        data_in = 8'h00;
        repeat (3) @(negedge sys_clk);
        do_arm(3'd0, 3'd5, 4'd0);
        goto_edge(700);
        sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done} !== 2'b00 || rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midpost_reset: got busy=%b done=%b rd_data=%0h expected 0 0 0", busy, done, rd_data);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        data_in   = 8'h33;
        do_arm(3'd0, 3'd5, 4'd0);
        wait_done(3000, e, g);
        n_tests++;
        if (done !== 1'b1 || e != 1024) begin
            n_fail++;
            $display("FAIL rearm_done: got done=%b edge=%0d expected 1 1024", done, e);
        end
        n_tests++;
        if (trig_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL rearm_trig_addr: got %0d expected 0", trig_addr);
        end
        read_buf(10'd0, v);
        n_tests++;
        if (v !== 8'h33) begin
            n_fail++;
            $display("FAIL rearm_rd0: got %0h expected 33", v);
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_pre_ignored();
        test_force_div();
        test_wrap();
        test_back_to_back();
        test_reset_mid_post();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
